// File: rtl/qlearn_episode_ctrl_if.sv
// Command, datapath and environment handshakes of the Q-learning episode controller.
// The controller uses the master view; the surrounding system uses the slave view.
interface qlearn_episode_ctrl_if #(
    parameter int STATES_WIDTH  = 4,
    parameter int ACTIONS_WIDTH = 2,
    parameter int DATA_WIDTH    = 16,
    parameter int MAX_STEPS     = 32,
    parameter int EP_WIDTH      = 8
);
    localparam int STEP_WIDTH = $clog2(MAX_STEPS + 1);

    logic                     i_start;
    logic [STATES_WIDTH-1:0]  i_first_st;
    logic [EP_WIDTH-1:0]      i_num_episodes;
    logic [7:0]               i_epsilon;
    logic                     o_query_valid;
    logic                     i_query_done;
    logic [ACTIONS_WIDTH-1:0] i_at_max;
    logic                     o_env_req;
    logic                     i_env_valid;
    logic [STATES_WIDTH-1:0]  i_env_next_st;
    logic [DATA_WIDTH-1:0]    i_env_rt;
    logic [STATES_WIDTH-1:0]  o_st;
    logic [ACTIONS_WIDTH-1:0] o_at;
    logic [STATES_WIDTH-1:0]  o_next_st;
    logic [DATA_WIDTH-1:0]    o_rt;
    logic                     o_upd_valid;
    logic                     i_upd_done;
    logic                     o_write_file_en;
    logic                     o_busy;
    logic                     o_done;
    logic [EP_WIDTH-1:0]      o_episode_cnt;
    logic [STEP_WIDTH-1:0]    o_step_cnt;

    modport master (
        input  i_start, i_first_st, i_num_episodes, i_epsilon,
        input  i_query_done, i_at_max, i_env_valid, i_env_next_st, i_env_rt, i_upd_done,
        output o_query_valid, o_env_req, o_st, o_at, o_next_st, o_rt, o_upd_valid,
        output o_write_file_en, o_busy, o_done, o_episode_cnt, o_step_cnt
    );

    modport slave (
        output i_start, i_first_st, i_num_episodes, i_epsilon,
        output i_query_done, i_at_max, i_env_valid, i_env_next_st, i_env_rt, i_upd_done,
        input  o_query_valid, o_env_req, o_st, o_at, o_next_st, o_rt, o_upd_valid,
        input  o_write_file_en, o_busy, o_done, o_episode_cnt, o_step_cnt
    );
endinterface

// File: rtl/qlearn_episode_ctrl.sv
// Episode controller for the Q-learning agent: runs N episodes, picks actions epsilon-greedily
// from the datapath's greedy action and a free-running LFSR, and issues one Q-update per step.
module qlearn_episode_ctrl #(
    parameter int STATES_WIDTH  = 4,
    parameter int ACTIONS_WIDTH = 2,
    parameter int DATA_WIDTH    = 16,
    parameter int MAX_STEPS     = 32,
    parameter int EP_WIDTH      = 8,
    parameter int GOAL_STATE    = 15
) (
    input  logic                  clk,
    input  logic                  rst_n,
    qlearn_episode_ctrl_if.master bus
);
    localparam int STEP_WIDTH = $clog2(MAX_STEPS + 1);
    localparam logic [STATES_WIDTH-1:0] GOAL_C     = STATES_WIDTH'(GOAL_STATE);
    localparam logic [STEP_WIDTH-1:0]   MAX_STEP_C = STEP_WIDTH'(MAX_STEPS);

    typedef enum logic [2:0] {
        IDLE, QUERY, WAIT_Q, ENV, UPDATE, WAIT_U, CHECK, FINISH
    } state_t;

    state_t                   state_r;
    logic [15:0]              lfsr_r;
    logic [STATES_WIDTH-1:0]  first_st_r;
    logic [EP_WIDTH-1:0]      num_ep_r;
    logic [7:0]               epsilon_r;
    logic [STATES_WIDTH-1:0]  st_r;
    logic [ACTIONS_WIDTH-1:0] at_r;
    logic [STATES_WIDTH-1:0]  next_st_r;
    logic [DATA_WIDTH-1:0]    rt_r;
    logic                     query_valid_r;
    logic                     env_req_r;
    logic                     upd_valid_r;
    logic                     write_file_en_r;
    logic                     busy_r;
    logic                     done_r;
    logic [EP_WIDTH-1:0]      ep_cnt_r;
    logic [STEP_WIDTH-1:0]    step_cnt_r;
    logic [EP_WIDTH-1:0]      ep_cnt_inc_s;

    // Fibonacci LFSR step, taps 16, 14, 13, 11
    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    assign ep_cnt_inc_s = ep_cnt_r + {{(EP_WIDTH-1){1'b0}}, 1'b1};

    // Episode FSM with all outputs registered; LFSR free-runs even while idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r         <= IDLE;
            lfsr_r          <= 16'hACE1;
            first_st_r      <= '0;
            num_ep_r        <= '0;
            epsilon_r       <= 8'd0;
            st_r            <= '0;
            at_r            <= '0;
            next_st_r       <= '0;
            rt_r            <= '0;
            query_valid_r   <= 1'b0;
            env_req_r       <= 1'b0;
            upd_valid_r     <= 1'b0;
            write_file_en_r <= 1'b0;
            busy_r          <= 1'b0;
            done_r          <= 1'b0;
            ep_cnt_r        <= '0;
            step_cnt_r      <= '0;
        end else begin
            lfsr_r          <= lfsr_next(lfsr_r);
            query_valid_r   <= 1'b0;
            upd_valid_r     <= 1'b0;
            write_file_en_r <= 1'b0;
            done_r          <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (bus.i_start) begin
                        first_st_r <= bus.i_first_st;
                        num_ep_r   <= bus.i_num_episodes;
                        epsilon_r  <= bus.i_epsilon;
                        st_r       <= bus.i_first_st;
                        ep_cnt_r   <= '0;
                        step_cnt_r <= '0;
                        busy_r     <= 1'b1;
                        state_r    <= (bus.i_num_episodes == '0) ? FINISH : QUERY;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                QUERY: begin
                    query_valid_r <= 1'b1;
                    state_r       <= WAIT_Q;
                end
                WAIT_Q: begin
                    if (bus.i_query_done) begin
                        // Explore with the LFSR's upper byte when its lower byte falls under epsilon
                        at_r      <= (lfsr_r[7:0] < epsilon_r) ? lfsr_r[8 +: ACTIONS_WIDTH]
                                                               : bus.i_at_max;
                        env_req_r <= 1'b1;
                        state_r   <= ENV;
                    end else begin
                        state_r <= WAIT_Q;
                    end
                end
                ENV: begin
                    if (bus.i_env_valid) begin
                        next_st_r <= bus.i_env_next_st;
                        rt_r      <= bus.i_env_rt;
                        env_req_r <= 1'b0;
                        state_r   <= UPDATE;
                    end else begin
                        state_r <= ENV;
                    end
                end
                UPDATE: begin
                    upd_valid_r <= 1'b1;
                    state_r     <= WAIT_U;
                end
                WAIT_U: begin
                    if (bus.i_upd_done) begin
                        write_file_en_r <= 1'b1;
                        step_cnt_r      <= step_cnt_r + {{(STEP_WIDTH-1){1'b0}}, 1'b1};
                        state_r         <= CHECK;
                    end else begin
                        state_r <= WAIT_U;
                    end
                end
                CHECK: begin
                    if ((next_st_r == GOAL_C) || (step_cnt_r == MAX_STEP_C)) begin
                        ep_cnt_r   <= ep_cnt_inc_s;
                        st_r       <= first_st_r;
                        step_cnt_r <= '0;
                        state_r    <= (ep_cnt_inc_s == num_ep_r) ? FINISH : QUERY;
                    end else begin
                        st_r    <= next_st_r;
                        state_r <= QUERY;
                    end
                end
                FINISH: begin
                    done_r  <= 1'b1;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    env_req_r <= 1'b0;
                    busy_r    <= 1'b0;
                    state_r   <= IDLE;
                end
            endcase
        end
    end

    assign bus.o_query_valid   = query_valid_r;
    assign bus.o_env_req       = env_req_r;
    assign bus.o_st            = st_r;
    assign bus.o_at            = at_r;
    assign bus.o_next_st       = next_st_r;
    assign bus.o_rt            = rt_r;
    assign bus.o_upd_valid     = upd_valid_r;
    assign bus.o_write_file_en = write_file_en_r;
    assign bus.o_busy          = busy_r;
    assign bus.o_done          = done_r;
    assign bus.o_episode_cnt   = ep_cnt_r;
    assign bus.o_step_cnt      = step_cnt_r;
endmodule

// File: tb/tb_qlearn_episode_ctrl.sv
// Randomised bench for qlearn_episode_ctrl: a negedge responder plays datapath and environment
// and checks every update against an episode-level model and an arithmetic LFSR model.
module tb_qlearn_episode_ctrl;
    localparam int SW   = 4;
    localparam int AW   = 2;
    localparam int DW   = 16;
    localparam int MS   = 32;
    localparam int EW   = 8;
    localparam int GOAL = 15;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    qlearn_episode_ctrl_if #(.STATES_WIDTH(SW), .ACTIONS_WIDTH(AW), .DATA_WIDTH(DW),
                             .MAX_STEPS(MS), .EP_WIDTH(EW)) bus ();

    qlearn_episode_ctrl #(.STATES_WIDTH(SW), .ACTIONS_WIDTH(AW), .DATA_WIDTH(DW),
                          .MAX_STEPS(MS), .EP_WIDTH(EW), .GOAL_STATE(GOAL)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Run configuration shared with the responder
    int cfg_first = 0, cfg_eps = 0, cfg_atmax = 0, cfg_mode = 0, cfg_delay = 0;
    bit cfg_stray = 1'b0, hold_upd = 1'b0;

    // Reference LFSR as plain integer arithmetic
    int ref_lfsr;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) ref_lfsr <= 'hACE1;
        else ref_lfsr <= ((ref_lfsr << 1) | (((ref_lfsr >> 15) ^ (ref_lfsr >> 13) ^
                          (ref_lfsr >> 12) ^ (ref_lfsr >> 10)) & 1)) & 'hFFFF;
    end

    int exp_at = 0, exp_next = 0, m_st = 0, m_steps = 0, m_ep = 0, req_cycles = 0;
    logic [15:0] exp_rt = 16'd0;
    int n_upd = 0, n_wfe = 0, n_query = 0, n_done = 0;
    int at_hist[4] = '{0, 0, 0, 0};

    // Datapath/environment responder and per-update scoreboard
    always @(negedge clk) begin
        bus.i_query_done = 1'b0;
        bus.i_env_valid  = 1'b0;
        bus.i_upd_done   = 1'b0;
        bus.i_at_max     = 2'(cfg_atmax);
        if (!rst_n) begin
            req_cycles = 0;
        end else begin
            if (!bus.o_busy) begin
                m_st = cfg_first; m_steps = 0; m_ep = 0; req_cycles = 0;
            end
            if (bus.o_query_valid) begin
                n_query++;
                bus.i_query_done = 1'b1;
                exp_at = ((ref_lfsr & 255) < cfg_eps) ? ((ref_lfsr >> 8) % 4) : cfg_atmax;
            end
            if (bus.o_env_req) begin
                req_cycles++;
                if (cfg_stray && req_cycles == 3) bus.i_upd_done = 1'b1;
                if (req_cycles > cfg_delay) begin
                    if (cfg_mode == 0) exp_next = (m_st + 1) % 16;
                    else if (cfg_mode == 1) exp_next = 3;
                    else exp_next = $urandom_range(0, 14);
                    exp_rt = 16'($urandom);
                    bus.i_env_valid   = 1'b1;
                    bus.i_env_next_st = 4'(exp_next);
                    bus.i_env_rt      = exp_rt;
                end
            end
            if (bus.o_upd_valid) begin
                n_upd++;
                check_val("upd_st", 32'(bus.o_st), 32'(m_st));
                check_val("upd_at", 32'(bus.o_at), 32'(exp_at));
                check_val("upd_next_st", 32'(bus.o_next_st), 32'(exp_next));
                check_val("upd_rt", 32'(bus.o_rt), 32'(exp_rt));
                check_val("upd_step_cnt", 32'(bus.o_step_cnt), 32'(m_steps));
                check_val("upd_ep_cnt", 32'(bus.o_episode_cnt), 32'(m_ep));
                check_val("env_req_held", 32'(req_cycles), 32'(cfg_delay + 1));
                req_cycles = 0;
                at_hist[bus.o_at]++;
                if (!hold_upd) bus.i_upd_done = 1'b1;
                m_steps++;
                if (exp_next == GOAL || m_steps == MS) begin
                    m_ep++; m_st = cfg_first; m_steps = 0;
                end else begin
                    m_st = exp_next;
                end
            end
            if (bus.o_write_file_en) n_wfe++;
            if (bus.o_done) n_done++;
        end
    end

    task automatic start_run(input int first, input int num, input int eps, input int atmax,
                             input int mode, input int delay, input bit stray);
        cfg_first = first; cfg_eps = eps; cfg_atmax = atmax;
        cfg_mode = mode; cfg_delay = delay; cfg_stray = stray;
        @(negedge clk);
        bus.i_first_st     = 4'(first);
        bus.i_num_episodes = 8'(num);
        bus.i_epsilon      = 8'(eps);
        bus.i_start        = 1'b1;
        @(negedge clk);
        bus.i_start        = 1'b0;
        // Scramble configuration to show it is latched, not re-sampled
        bus.i_first_st     = 4'($urandom);
        bus.i_num_episodes = 8'($urandom);
        bus.i_epsilon      = 8'($urandom);
    endtask

    task automatic wait_done(input string tag, input int budget, input int num, input int first);
        bit seen = 1'b0;
        for (int c = 0; c < budget && !seen; c++) begin
            @(negedge clk);
            if (bus.o_done) seen = 1'b1;
        end
        check_val({tag, "_done_seen"}, 32'(seen), 32'd1);
        @(negedge clk);
        check_val({tag, "_ep_cnt"}, 32'(bus.o_episode_cnt), 32'(num));
        check_val({tag, "_step_cnt"}, 32'(bus.o_step_cnt), 32'd0);
        check_val({tag, "_st_reload"}, 32'(bus.o_st), 32'(first));
        check_val({tag, "_busy"}, 32'(bus.o_busy), 32'd0);
    endtask

    int s_upd, s_wfe, s_done, s_query;
    int h0[4];
    bit got;

    initial begin
        bus.i_start = 1'b0; bus.i_first_st = '0; bus.i_num_episodes = '0; bus.i_epsilon = 8'd0;
        bus.i_env_next_st = '0; bus.i_env_rt = '0;
        repeat (3) @(negedge clk);
        check_val("rst_busy", 32'(bus.o_busy), 32'd0);
        check_val("rst_st", 32'(bus.o_st), 32'd0);
        check_val("rst_ep_cnt", 32'(bus.o_episode_cnt), 32'd0);
        check_val("rst_query", 32'(bus.o_query_valid), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single greedy episode, 0 -> 15
        s_upd = n_upd; s_wfe = n_wfe; s_done = n_done; h0 = at_hist;
        start_run(0, 1, 0, 2, 0, 0, 1'b0);
        wait_done("greedy", 400, 1, 0);
        check_val("greedy_upd", 32'(n_upd - s_upd), 32'd15);
        check_val("greedy_wfe", 32'(n_wfe - s_wfe), 32'd15);
        check_val("greedy_done", 32'(n_done - s_done), 32'd1);
        check_val("greedy_at2", 32'(at_hist[2] - h0[2]), 32'd15);

        // Step limit: never reaches goal, two episodes of MAX_STEPS
        s_upd = n_upd;
        start_run(5, 2, 0, 1, 1, 0, 1'b0);
        wait_done("steplim", 2000, 2, 5);
        check_val("steplim_upd", 32'(n_upd - s_upd), 32'(2 * MS));

        // Exploration with full epsilon
        s_upd = n_upd; h0 = at_hist;
        start_run(0, 7, 255, 0, 2, 0, 1'b0);
        wait_done("explore", 3000, 7, 0);
        check_val("explore_upd", 32'(n_upd - s_upd), 32'(7 * MS));
        for (int a = 0; a < 4; a++)
            check_val($sformatf("explore_at%0d_seen", a), 32'(at_hist[a] > h0[a]), 32'd1);

        // Zero episodes
        s_query = n_query; s_done = n_done;
        start_run(7, 0, 0, 0, 0, 0, 1'b0);
        check_val("zero_done_early", 32'(bus.o_done), 32'd0);
        @(negedge clk);
        check_val("zero_done_2cyc", 32'(bus.o_done), 32'd1);
        @(negedge clk);
        check_val("zero_ep_cnt", 32'(bus.o_episode_cnt), 32'd0);
        check_val("zero_query", 32'(n_query - s_query), 32'd0);
        check_val("zero_done_cnt", 32'(n_done - s_done), 32'd1);

        // Environment stall with stray update strobe
        s_upd = n_upd; s_wfe = n_wfe;
        start_run(14, 1, 0, 3, 0, 10, 1'b1);
        wait_done("stall", 400, 1, 14);
        check_val("stall_upd", 32'(n_upd - s_upd), 32'd1);
        check_val("stall_wfe", 32'(n_wfe - s_wfe), 32'd1);
        cfg_stray = 1'b0;

        // Reset while waiting for the update to complete
        hold_upd = 1'b1;
        start_run(9, 1, 0, 1, 0, 0, 1'b0);
        got = 1'b0;
        for (int c = 0; c < 100 && !got; c++) begin
            @(negedge clk);
            if (bus.o_upd_valid) got = 1'b1;
        end
        check_val("rstmid_upd_seen", 32'(got), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_val("rstmid_busy", 32'(bus.o_busy), 32'd0);
        check_val("rstmid_st", 32'(bus.o_st), 32'd0);
        check_val("rstmid_at", 32'(bus.o_at), 32'd0);
        check_val("rstmid_next_st", 32'(bus.o_next_st), 32'd0);
        check_val("rstmid_rt", 32'(bus.o_rt), 32'd0);
        check_val("rstmid_upd", 32'(bus.o_upd_valid), 32'd0);
        check_val("rstmid_wfe", 32'(bus.o_write_file_en), 32'd0);
        check_val("rstmid_done", 32'(bus.o_done), 32'd0);
        check_val("rstmid_env_req", 32'(bus.o_env_req), 32'd0);
        check_val("rstmid_step_cnt", 32'(bus.o_step_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        hold_upd = 1'b0;
        @(negedge clk);
        check_val("rstmid_idle", 32'(bus.o_busy), 32'd0);
        s_upd = n_upd;
        start_run(12, 2, 0, 0, 0, 0, 1'b0);
        wait_done("after_rst", 400, 2, 12);
        check_val("after_rst_upd", 32'(n_upd - s_upd), 32'd6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
